norm_ctrl: RTL and testbench
============================

NORM_CTRL -- requirements
Module: norm_ctrl

Interface
REQ-001 The block SHALL have parameter COL, default 8, meaning words per psum row and beats per normalizer output burst.
REQ-002 The block SHALL have parameter BW_PSUM, default 16, meaning bits per psum word.
REQ-003 The block SHALL have parameter W_OUT, default 16, meaning bits per normalized word.
REQ-004 The block SHALL have parameter ADDR_W, default 6, meaning row address width of the psum and output buffers.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles in WAIT without a norm_valid beat.
REQ-006 The block SHALL use clock clk; reset reset, synchronous, active-high.
REQ-007 The block SHALL have the following ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle job start request
- num_rows  in  ADDR_W+1  rows in the job, sampled at accepted start
- busy  out  1  job in progress
- done  out  1  one-cycle job completion pulse
- err  out  1  sticky error flag, cleared only by the next accepted start or by reset
- rd_en  out  1  psum buffer read enable; read data valid next cycle
- rd_addr  out  ADDR_W  psum buffer row address
- s_valid  out  1  psum row valid strobe to the normalizer
- norm_valid  in  1  normalizer output beat valid
- psum_norm  in  W_OUT  normalizer output word
- wr_en  out  1  output buffer row write enable
- wr_addr  out  ADDR_W  output buffer row address
- wr_data  out  COL*W_OUT  packed normalized row; word 0 in the LSBs

Function
REQ-008 The FSM SHALL have states IDLE, READ, ISSUE, WAIT, WRITE, FIN.
REQ-009 In IDLE, start SHALL be accepted: latch num_rows, clear row counter and err; go to FIN if num_rows==0, else to READ.
REQ-010 start SHALL be ignored in every state other than IDLE.
REQ-011 READ SHALL assert rd_en=1 with rd_addr=row for exactly one cycle, then go to ISSUE.
REQ-012 ISSUE SHALL assert s_valid=1 for exactly one cycle (read data valid), then go to WAIT with beat counter and timeout counter at 0.
REQ-013 In WAIT, each norm_valid beat SHALL store psum_norm into word slot beat_cnt of the packer and increment beat_cnt.
REQ-014 The COL-th beat SHALL move the FSM to WRITE on the next cycle.
REQ-015 In WAIT, the timeout counter SHALL increment on every cycle without norm_valid and reset to 0 on a beat.
REQ-016 When the timeout counter reaches TIMEOUT, the block SHALL set err=1 and go to FIN without writing the row.
REQ-017 WRITE SHALL assert wr_en=1 for one cycle with wr_addr=row and wr_data=packed row.
REQ-018 After WRITE, the block SHALL go to FIN if row==num_rows-1; otherwise it SHALL increment row and go to READ.
REQ-019 FIN SHALL assert done=1 for one cycle, then go to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 A norm_valid beat outside WAIT SHALL be discarded and SHALL set err=1; the FSM SHALL be unaffected.
REQ-022 Row latency, excluding normalizer processing time, SHALL be: READ 1 cycle + ISSUE 1 cycle + COL beats + WRITE 1 cycle.
REQ-023 rd_en, s_valid, wr_en and done SHALL be registered outputs and SHALL never be asserted simultaneously.
REQ-024 The counter widths SHALL be: row ADDR_W+1, beat_cnt $clog2(COL)+1, timeout counter $clog2(TIMEOUT+1); no counter SHALL wrap within a legal job (num_rows ≤ 2**ADDR_W).

Reset
REQ-025 Reset SHALL force state IDLE and set busy, done, err, rd_en, s_valid and wr_en to 0; rd_addr, wr_addr, wr_data and all counters to 0.
REQ-026 Reset asserted mid-job SHALL abort the job with no further write and no done pulse.

Structure
REQ-027 Package norm_pkg SHALL hold the state enum norm_state_t and the default COL and W_OUT constants.
REQ-028 The beat-to-row packing register SHALL be a sub-module norm_packer (inputs clear, beat, word, index; output row).

Verification
REQ-029 The bench SHALL apply COL=8, num_rows=3, with the model returning 8 beats of 0x10..0x17 per row; required response: 3 wr_en pulses at addresses 0,1,2 with wr_data word i = 0x10+i, and done exactly once.
REQ-030 The bench SHALL apply num_rows=0; required response: done the cycle after FIN is entered, with no rd_en and no wr_en.
REQ-031 The bench SHALL stall the model after 5 beats with TIMEOUT=20; required response: err=1 at 20 idle cycles, no wr_en, then done and return to IDLE.
REQ-032 The bench SHALL pulse start during WAIT of row 1; required response: the pulse is ignored, and rows and addresses are unchanged.
REQ-033 The bench SHALL pulse norm_valid in IDLE; required response: err=1, and a following start clears err and completes normally.
REQ-034 The bench SHALL assert reset during WAIT of row 2 of 4; required response: all outputs 0 next cycle, no done, and a subsequent job runs from row 0.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and default sizes for the psum normalization controller.
package norm_pkg;

  localparam int COL_DEF   = 8;
  localparam int W_OUT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    FIN   = 3'd5
  } norm_state_t;

endpackage

// File: rtl/norm_packer.sv
// Collects normalizer output beats into one packed row, word 0 in the LSBs.
module norm_packer #(
  parameter int COL   = 8,
  parameter int W_OUT = 16,
  parameter int IW    = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 beat,
  input  logic [W_OUT-1:0]     word,
  input  logic [IW-1:0]        index,
  output logic [COL*W_OUT-1:0] row
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= '0;
    end else if (beat) begin
      row[index*W_OUT +: W_OUT] <= word;
    end
  end

endmodule

// File: rtl/norm_ctrl.sv
// Row sequencer: reads each psum row, hands it to the normalizer, gathers COL
// output beats and writes the packed row, with a watchdog on stalled beats.
module norm_ctrl
  import norm_pkg::*;
#(
  parameter int COL     = COL_DEF,
  parameter int BW_PSUM = 16,
  parameter int W_OUT   = W_OUT_DEF,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_rows,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 s_valid,
  input  logic                 norm_valid,
  input  logic [W_OUT-1:0]     psum_norm,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [COL*W_OUT-1:0] wr_data
);

  localparam int RW = ADDR_W + 1;
  localparam int BW = $clog2(COL) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (COL > 1) ? $clog2(COL) : 1;

  // The psum width only matters to the normalizer; reject nonsense sizes early.
  if (BW_PSUM < 1 || COL < 1 || TIMEOUT < 1 || ADDR_W < 1) begin : g_param_check
    $error("norm_ctrl: illegal parameter value");
  end

  norm_state_t state, next_state;

  logic [RW-1:0] row;
  logic [RW-1:0] rows_q;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] tmo_cnt;

  logic start_ok;
  logic beat_in_wait;
  logic last_beat;
  logic timed_out;
  logic last_row;
  logic stray_beat;

  always_comb begin
    next_state   = state;
    start_ok     = (state == IDLE) && start;
    beat_in_wait = (state == WAIT) && norm_valid;
    stray_beat   = (state != WAIT) && norm_valid;
    last_beat    = beat_in_wait && (beat_cnt == BW'(COL - 1));
    timed_out    = (state == WAIT) && !norm_valid && (tmo_cnt == TW'(TIMEOUT - 1));
    last_row     = (row == rows_q - RW'(1));

    case (state)
      IDLE:    if (start) next_state = (num_rows == '0) ? FIN : READ;
      READ:    next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT: begin
        if (last_beat)      next_state = WRITE;
        else if (timed_out) next_state = FIN;
      end
      WRITE:   next_state = last_row ? FIN : READ;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are decoded from next_state so each one is a flop aligned with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_en    <= 1'b0;
      s_valid  <= 1'b0;
      wr_en    <= 1'b0;
      row      <= '0;
      rows_q   <= '0;
      beat_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state   <= next_state;
      busy    <= (next_state != IDLE);
      done    <= (next_state == FIN);
      rd_en   <= (next_state == READ);
      s_valid <= (next_state == ISSUE);
      wr_en   <= (next_state == WRITE);

      if (start_ok) begin
        rows_q <= num_rows;
        row    <= '0;
      end else if (state == WRITE && !last_row) begin
        row <= row + RW'(1);
      end

      if (state == ISSUE) begin
        beat_cnt <= '0;
        tmo_cnt  <= '0;
      end else if (beat_in_wait) begin
        beat_cnt <= beat_cnt + BW'(1);
        tmo_cnt  <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      // A stray beat in IDLE outranks the clear from a simultaneous start.
      if (timed_out || stray_beat) begin
        err <= 1'b1;
      end else if (start_ok) begin
        err <= 1'b0;
      end
    end
  end

  assign rd_addr = row[ADDR_W-1:0];
  assign wr_addr = row[ADDR_W-1:0];

  norm_packer #(
    .COL   (COL),
    .W_OUT (W_OUT),
    .IW    (IW)
  ) u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (state == ISSUE),
    .beat  (beat_in_wait),
    .word  (psum_norm),
    .index (beat_cnt[IW-1:0]),
    .row   (wr_data)
  );

endmodule

// File: tb/tb_norm_ctrl.sv
// Scoreboard bench for norm_ctrl with a behavioural normalizer model.
module tb_norm_ctrl;

  localparam int COL     = 8;
  localparam int BW_PSUM = 16;
  localparam int W_OUT   = 16;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 20;
  localparam int DW      = COL * W_OUT;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   num_rows;
  logic              busy, done, err, rd_en, s_valid, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              norm_valid;
  logic [W_OUT-1:0]  psum_norm;
  logic [DW-1:0]     wr_data;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  wr_exp_t exp_wr[$];
  int      exp_rd[$];
  bit      exp_done[$];

  logic [W_OUT-1:0] job_words [64][COL];
  int stall_after = -1;
  int poke_cnt    = 0;
  int poke_seen   = 0;
  int model_row   = 0;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  norm_ctrl #(
    .COL     (COL),
    .BW_PSUM (BW_PSUM),
    .W_OUT   (W_OUT),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_rows   (num_rows),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .s_valid    (s_valid),
    .norm_valid (norm_valid),
    .psum_norm  (psum_norm),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  function automatic void check_output(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin : monitor
    int      strobes;
    int      ea;
    wr_exp_t ew;
    bit      ed;
    strobes = int'(rd_en) + int'(s_valid) + int'(wr_en) + int'(done);
    if (strobes != 0) check_output("strobe_onehot", DW'(strobes), DW'(1));
    if (rd_en) begin
      check_output("rd_expected", DW'(exp_rd.size() != 0), DW'(1));
      if (exp_rd.size() != 0) begin
        ea = exp_rd.pop_front();
        check_output("rd_addr", DW'(rd_addr), DW'(ea));
      end
    end
    if (wr_en) begin
      check_output("wr_expected", DW'(exp_wr.size() != 0), DW'(1));
      if (exp_wr.size() != 0) begin
        ew = exp_wr.pop_front();
        check_output("wr_addr", DW'(wr_addr), DW'(ew.addr));
        check_output("wr_data", wr_data, ew.data);
      end
    end
    if (done) begin
      check_output("done_expected", DW'(exp_done.size() != 0), DW'(1));
      if (exp_done.size() != 0) begin
        ed = exp_done.pop_front();
        check_output("err_at_done", DW'(err), DW'(ed));
      end
    end
  end

  // Normalizer model: after each s_valid returns COL beats with random gaps.
  task automatic serve_row();
    int r;
    int gap;
    r = model_row;
    model_row++;
    @(negedge clk);
    for (int i = 0; i < COL; i++) begin
      if (stall_after >= 0 && i == stall_after) begin
        repeat (TIMEOUT - 1) @(negedge clk);
        check_output("err_before_timeout", DW'(err), DW'(0));
        @(negedge clk);
        check_output("err_at_timeout", DW'(err), DW'(1));
        check_output("done_at_timeout", DW'(done), DW'(1));
        @(negedge clk);
        check_output("idle_after_timeout", DW'(busy), DW'(0));
        model_row = 0;
        return;
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        if (reset) begin
          model_row = 0;
          return;
        end
        @(negedge clk);
      end
      if (reset) begin
        model_row = 0;
        return;
      end
      norm_valid = 1'b1;
      psum_norm  = job_words[r][i];
      @(negedge clk);
      norm_valid = 1'b0;
      if (reset) begin
        model_row = 0;
        return;
      end
    end
    check_output("write_after_last_beat", DW'(wr_en), DW'(1));
  endtask

  initial begin : normalizer
    norm_valid = 1'b0;
    psum_norm  = '0;
    forever begin
      @(negedge clk);
      if (reset || done) begin
        model_row = 0;
      end else if (poke_cnt != poke_seen) begin
        poke_seen  = poke_cnt;
        norm_valid = 1'b1;
        psum_norm  = W_OUT'($urandom);
        @(negedge clk);
        norm_valid = 1'b0;
      end else if (s_valid) begin
        serve_row();
      end
    end
  end

  task automatic wait_svalid(input int n);
    int cnt;
    cnt = 0;
    for (int c = 0; c < 5000 && cnt < n; c++) begin
      @(negedge clk);
      if (s_valid) cnt++;
    end
    check_output("svalid_seen", DW'(cnt), DW'(n));
  endtask

  task automatic apply_stimulus(input int nrows, input bit fixed, input int stall,
                                input int glitch_row, input int reset_row);
    int            written;
    int            reads;
    bit            seen;
    wr_exp_t       w;
    for (int r = 0; r < nrows; r++)
      for (int i = 0; i < COL; i++)
        job_words[r][i] = fixed ? W_OUT'(16'h10 + i) : W_OUT'($urandom);
    written = nrows;
    reads   = nrows;
    if (stall >= 0) begin
      written = 0;
      reads   = (nrows > 0) ? 1 : 0;
    end
    if (reset_row >= 0) begin
      written = reset_row;
      reads   = reset_row + 1;
    end
    for (int r = 0; r < written; r++) begin
      w.addr = r;
      w.data = '0;
      for (int i = 0; i < COL; i++) w.data[i*W_OUT +: W_OUT] = job_words[r][i];
      exp_wr.push_back(w);
    end
    for (int r = 0; r < reads; r++) exp_rd.push_back(r);
    if (reset_row < 0) exp_done.push_back(stall >= 0);
    stall_after = stall;

    @(negedge clk);
    start    = 1'b1;
    num_rows = (ADDR_W + 1)'(nrows);
    @(negedge clk);
    start = 1'b0;
    if (nrows == 0) check_output("done_after_fin", DW'(done), DW'(1));

    if (glitch_row >= 0) begin
      wait_svalid(glitch_row + 1);
      @(negedge clk);
      start    = 1'b1;
      num_rows = (ADDR_W + 1)'(5);
      @(negedge clk);
      start = 1'b0;
    end

    if (reset_row >= 0) begin
      wait_svalid(reset_row + 1);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_output("abort_ctrl", DW'({busy, done, err, rd_en, s_valid, wr_en}), DW'(0));
      check_output("abort_addr", DW'({rd_addr, wr_addr}), DW'(0));
      check_output("abort_data", wr_data, DW'(0));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
    end else if (nrows != 0) begin
      seen = 1'b0;
      for (int c = 0; c < 20000 && !seen; c++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check_output("done_seen", DW'(seen), DW'(1));
    end

    repeat (4) @(negedge clk);
    stall_after = -1;
    check_output("wr_left", DW'(exp_wr.size()), DW'(0));
    check_output("rd_left", DW'(exp_rd.size()), DW'(0));
    check_output("done_left", DW'(exp_done.size()), DW'(0));
    check_output("idle_after_job", DW'(busy), DW'(0));
  endtask

  initial begin : stimulus
    reset    = 1'b1;
    start    = 1'b0;
    num_rows = '0;
    repeat (3) @(negedge clk);
    check_output("reset_ctrl", DW'({busy, done, err, rd_en, s_valid, wr_en}), DW'(0));
    check_output("reset_addr", DW'({rd_addr, wr_addr}), DW'(0));
    check_output("reset_data", wr_data, DW'(0));
    reset = 1'b0;

    $display("[TB] three rows of fixed words");
    apply_stimulus(3, 1'b1, -1, -1, -1);

    $display("[TB] empty job");
    apply_stimulus(0, 1'b0, -1, -1, -1);

    $display("[TB] normalizer stall after 5 beats");
    apply_stimulus(2, 1'b0, 5, -1, -1);

    $display("[TB] start pulse during row 1");
    apply_stimulus(3, 1'b0, -1, 1, -1);

    $display("[TB] stray beat in idle");
    poke_cnt++;
    repeat (3) @(negedge clk);
    check_output("err_idle_beat", DW'(err), DW'(1));
    check_output("busy_idle_beat", DW'(busy), DW'(0));
    apply_stimulus(2, 1'b0, -1, -1, -1);

    $display("[TB] reset during row 2 of 4");
    apply_stimulus(4, 1'b0, -1, -1, 2);
    apply_stimulus(2, 1'b0, -1, -1, -1);

    $display("[TB] random jobs");
    for (int k = 0; k < 4; k++) apply_stimulus(int'($urandom_range(1, 6)), 1'b0, -1, -1, -1);

    $display("[TB] full-depth job");
    apply_stimulus(64, 1'b0, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
